// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : PC holder and req/ack instruction fetcher feeding the decoder;
//            resolves sequential / branch / jump next-PC from J, B and zero.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned IMEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        J,
   input  logic        B,
   input  logic        zero,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opCode,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);

   localparam int unsigned c_CNT_W = $clog2(IMEM_TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT      = c_CNT_W'(IMEM_TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(IMEM_TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic [31:0]         r_pc;
   logic [31:0]         r_instr;
   logic [c_CNT_W-1:0]  r_waitCnt;
   logic                r_fetchErr;

   logic                w_imemReq;
   logic                w_instrValid;
   logic                w_capture;
   logic                w_advance;
   logic [31:0]         w_pcPlus4;
   logic [31:0]         w_jumpTarget;
   logic [31:0]         w_brOffset;
   logic [31:0]         w_branchTarget;
   logic [31:0]         w_nextPc;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext  = r_state;
      w_imemReq    = 1'b0;
      w_instrValid = 1'b0;
      w_capture    = 1'b0;
      w_advance    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_stateNext = S_FETCH;
         end
         S_FETCH: begin
            w_imemReq = 1'b1;
            if (imem_ack) begin
               w_capture   = 1'b1;
               w_stateNext = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_instrValid = 1'b1;
            if (!stall) begin
               w_advance   = 1'b1;
               w_stateNext = S_FETCH;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-PC resolution: jump beats taken branch beats sequential
   // ------------------------------------------------------------------------
   assign w_pcPlus4      = r_pc + 32'd4;
   assign w_jumpTarget   = {w_pcPlus4[31:28], r_instr[25:0], 2'b00};
   assign w_brOffset     = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_branchTarget = w_pcPlus4 + w_brOffset;

   // Comparing against 1'b1 makes an unknown J/B fall through to sequential
   always_comb begin
      w_nextPc = w_pcPlus4;
      if (J == 1'b1) begin
         w_nextPc = w_jumpTarget;
      end else if ((B == 1'b1) && (zero == 1'b1)) begin
         w_nextPc = w_branchTarget;
      end
   end

   // ------------------------------------------------------------------------
   // PC and instruction registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= {RESET_PC[31:2], 2'b00};
         r_instr <= 32'h0000_0000;
      end else begin
         if (w_capture) begin
            r_instr <= imem_rdata;
         end
         if (w_advance) begin
            r_pc <= {w_nextPc[31:2], 2'b00};
         end
      end
   end

   // ------------------------------------------------------------------------
   // Fetch timeout: saturating wait counter, sticky error flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waitCnt  <= '0;
         r_fetchErr <= 1'b0;
      end else if (r_state == S_FETCH) begin
         if (imem_ack) begin
            r_waitCnt <= '0;
         end else begin
            if (r_waitCnt != c_TIMEOUT) begin
               r_waitCnt <= r_waitCnt + c_CNT_ONE;
            end
            if (r_waitCnt >= c_TIMEOUT_LAST) begin
               r_fetchErr <= 1'b1;
            end
         end
      end
   end

   assign imem_req    = w_imemReq;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign pc_plus4    = w_pcPlus4;
   assign instr       = r_instr;
   assign opCode      = r_instr[31:26];
   assign instr_valid = w_instrValid;
   assign fetch_err   = r_fetchErr;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Directed, table-driven self-checking bench for inst_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

   logic        clk;
   logic        rst_n;
   logic        J, B, zero, stall;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   logic        imemReq,  imemReqW;
   logic [31:0] imemAddr, imemAddrW;
   logic [31:0] instr,    instrW;
   logic [5:0]  opCode,   opCodeW;
   logic        instrValid, instrValidW;
   logic [31:0] pc,       pcW;
   logic [31:0] pcPlus4,  pcPlus4W;
   logic        fetchErr, fetchErrW;

   int nChecks = 0;
   int nFails  = 0;

   inst_fetch #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .J(J), .B(B), .zero(zero), .stall(stall),
      .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instr), .opCode(opCode),
      .instr_valid(instrValid), .pc(pc), .pc_plus4(pcPlus4),
      .fetch_err(fetchErr)
   );

   // Second instance runs in lockstep to cover the top-of-memory wrap
   inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(16)) dutWrap (
      .clk(clk), .rst_n(rst_n), .J(J), .B(B), .zero(zero), .stall(stall),
      .imem_req(imemReqW), .imem_addr(imemAddrW), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instrW), .opCode(opCodeW),
      .instr_valid(instrValidW), .pc(pcW), .pc_plus4(pcPlus4W),
      .fetch_err(fetchErrW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      logic        j;
      logic        b;
      logic        z;
      logic [31:0] expNext;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full fetch/issue round: zero-wait ack, then resolve next PC
   task automatic applyVec(input int i);
      logic [31:0] w;
      w = vecs[i].word;
      check($sformatf("v%0d fetch req", i), {31'd0, imemReq}, 32'd1);
      check($sformatf("v%0d fetch addr", i), imemAddr, vecs[i].addr);
      check($sformatf("v%0d fetch valid", i), {31'd0, instrValid}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = w;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check($sformatf("v%0d issue valid", i), {31'd0, instrValid}, 32'd1);
      check($sformatf("v%0d issue req", i), {31'd0, imemReq}, 32'd0);
      check($sformatf("v%0d instr", i), instr, w);
      check($sformatf("v%0d opCode", i), {26'd0, opCode}, {26'd0, w[31:26]});
      check($sformatf("v%0d pc", i), pc, vecs[i].addr);
      check($sformatf("v%0d pc_plus4", i), pcPlus4, vecs[i].addr + 32'd4);
      J    = vecs[i].j;
      B    = vecs[i].b;
      zero = vecs[i].z;
      step();
      J = 1'b0; B = 1'b0; zero = 1'b0;
      check($sformatf("v%0d next addr", i), imemAddr, vecs[i].expNext);
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
      vecs[1]  = '{32'h0000_0004, 32'h2001_0005, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
      vecs[2]  = '{32'h0000_0008, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_000C};
      vecs[3]  = '{32'h0000_000C, 32'h0810_0004, 1'b1, 1'b0, 1'b0, 32'h0040_0010};
      vecs[4]  = '{32'h0040_0010, 32'h0810_0020, 1'b1, 1'b0, 1'b0, 32'h0040_0080};
      vecs[5]  = '{32'h0040_0080, 32'h0810_0020, 1'b1, 1'b1, 1'b1, 32'h0040_0080};
      vecs[6]  = '{32'h0040_0080, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'h0040_007C};
      vecs[7]  = '{32'h0040_007C, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h0040_0080};
      vecs[8]  = '{32'h0040_0080, 32'h1000_0010, 1'b0, 1'b1, 1'b1, 32'h0040_00C4};
      vecs[9]  = '{32'h0040_00C4, 32'hAC00_0000, 1'b0, 1'b0, 1'b1, 32'h0040_00C8};
      vecs[10] = '{32'h0040_00C8, 32'h0800_0040, 1'b1, 1'b0, 1'b0, 32'h0000_0100};
      vecs[11] = '{32'h0000_0100, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'h0000_00FC};
      vecs[12] = '{32'h0000_00FC, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
      vecs[13] = '{32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0104};

      rst_n = 1'b0; J = 1'b0; B = 1'b0; zero = 1'b0; stall = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      repeat (3) step();

      check("rst req", {31'd0, imemReq}, 32'd0);
      check("rst pc", pc, 32'h0);
      check("rst instr", instr, 32'h0);
      check("rst valid", {31'd0, instrValid}, 32'd0);
      check("rst err", {31'd0, fetchErr}, 32'd0);
      check("rst opCode", {26'd0, opCode}, 32'd0);

      // Release, IDLE for one cycle, then FETCH
      rst_n = 1'b1;
      check("idle req", {31'd0, imemReq}, 32'd0);
      step();
      check("first fetch req", {31'd0, imemReq}, 32'd1);

      // Reset mid-FETCH drops the request without a clock edge
      #2;
      rst_n = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'h1234_5678;
      #1;
      check("async rst req", {31'd0, imemReq}, 32'd0);
      check("async rst valid", {31'd0, instrValid}, 32'd0);
      step();
      check("late ack ignored", instr, 32'h0);
      rst_n = 1'b1;
      step();
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      check("idle ack ignored", instr, 32'h0);

      // Wrap instance: reset PC at top of memory
      check("wrap addr0", imemAddrW, 32'hFFFF_FFFC);
      check("wrap pc_plus4", pcPlus4W, 32'h0000_0000);
      applyVec(0);
      check("wrap addr1", imemAddrW, 32'h0000_0000);
      for (int i = 1; i < 14; i++) begin
         applyVec(i);
      end

      // Stall holds the issued instruction; branch inputs wait for release
      check("stall fetch addr", imemAddr, 32'h0000_0104);
      imem_ack = 1'b1;
      imem_rdata = 32'h1000_0003;
      step();
      imem_ack = 1'b0;
      stall = 1'b1; B = 1'b1; zero = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("stall%0d pc", k), pc, 32'h0000_0104);
         check($sformatf("stall%0d instr", k), instr, 32'h1000_0003);
         check($sformatf("stall%0d req", k), {31'd0, imemReq}, 32'd0);
         check($sformatf("stall%0d valid", k), {31'd0, instrValid}, 32'd1);
      end
      stall = 1'b0;
      step();
      B = 1'b0; zero = 1'b0;
      check("post-stall branch addr", imemAddr, 32'h0000_0114);
      check("post-stall valid", {31'd0, instrValid}, 32'd0);

      // Two wait states; stall during FETCH has no effect
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("wait%0d req", k), {31'd0, imemReq}, 32'd1);
         check($sformatf("wait%0d instr held", k), instr, 32'h1000_0003);
         step();
      end
      check("wait ack req", {31'd0, imemReq}, 32'd1);
      imem_ack = 1'b1;
      imem_rdata = 32'h2002_0007;
      step();
      imem_ack = 1'b0;
      stall = 1'b0;
      check("wait instr", instr, 32'h2002_0007);
      check("wait opCode", {26'd0, opCode}, 32'h0000_0008);
      check("wait valid", {31'd0, instrValid}, 32'd1);
      check("wait no err", {31'd0, fetchErr}, 32'd0);
      step();
      check("wait next addr", imemAddr, 32'h0000_0118);

      // Timeout after 16 FETCH cycles without ack
      repeat (15) step();
      check("timeout 15 err", {31'd0, fetchErr}, 32'd0);
      check("timeout 15 req", {31'd0, imemReq}, 32'd1);
      step();
      check("timeout 16 err", {31'd0, fetchErr}, 32'd1);
      repeat (3) step();
      check("timeout sticky", {31'd0, fetchErr}, 32'd1);
      check("timeout req kept", {31'd0, imemReq}, 32'd1);
      check("timeout addr kept", imemAddr, 32'h0000_0118);
      imem_ack = 1'b1;
      imem_rdata = 32'h0000_0000;
      step();
      imem_ack = 1'b0;
      check("timeout ack valid", {31'd0, instrValid}, 32'd1);
      check("err sticky on ack", {31'd0, fetchErr}, 32'd1);
      step();
      check("err sticky next", {31'd0, fetchErr}, 32'd1);
      check("after timeout addr", imemAddr, 32'h0000_011C);

      rst_n = 1'b0;
      #1;
      check("err cleared by rst", {31'd0, fetchErr}, 32'd0);
      check("rst pc again", pc, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      step();
      check("err stays clear", {31'd0, fetchErr}, 32'd0);
      check("refetch addr", imemAddr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and fetches one 32-bit word per instruction from instruction memory over a req/ack handshake.
- Presents the instruction and its opCode (instr[31:26]) to the decoder.
- Consumes the decoder's J and B outputs, plus the ALU zero flag, to select the next PC: sequential, branch, or jump.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- IMEM_TIMEOUT, 16: maximum cycles to wait for imem_ack before flagging fetch_err.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- J  in  1  jump select from main controller.
- B  in  1  branch select from main controller.
- zero  in  1  ALU zero flag for beq resolution.
- stall  in  1  downstream hold; keeps the current instruction issued.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  memory accepted the request; imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  registered current instruction.
- opCode  out  6  instr[31:26], drives the decoder.
- instr_valid  out  1  instr/opCode valid for decode/execute.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, combinational.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, state=IDLE.
  - Outputs change immediately, without waiting for a clock edge.
  - A reset during FETCH drops imem_req at once. A late imem_ack after reset is ignored.
- States:
  - IDLE: one cycle after reset release, then go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack: instr<=imem_rdata, then go to ISSUE.
    - Timeout counter increments each FETCH cycle without ack. When it reaches IMEM_TIMEOUT: set fetch_err, stay in FETCH, keep requesting.
    - Counter clears on ack.
  - ISSUE: instr_valid=1, imem_req=0.
    - If stall=1: hold instr and pc unchanged.
    - If stall=0: pc<=next_pc, go to FETCH, instr_valid drops the next cycle.
- Latency: a zero-wait memory (ack in the first FETCH cycle) gives one instruction every 2 cycles. Each added wait cycle adds one.
- next_pc is evaluated in the ISSUE cycle. Priority, highest first:
  - J=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - B=1 && zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Otherwise: pc_plus4.
- Resolution rules:
  - J and B both 1: J wins.
  - Any X on J or B (don't-care decode) in ISSUE is treated as 0.
  - A default opcode (all decoder outputs 0) falls through to pc_plus4.
- Arithmetic: all 32-bit modulo 2^32.
  - pc_plus4 of 32'hFFFF_FFFC is 32'h0000_0000.
  - Branch targets wrap the same way.
  - pc[1:0] is always 00.
- Ignored inputs:
  - imem_ack outside FETCH.
  - stall outside ISSUE.
- fetch_err clears only on reset.
- opCode is always instr[31:26], including while instr_valid=0.

Test Plan:
- Reset then sequential fetch: rst_n low mid-FETCH with imem_req=1 -> imem_req falls immediately. Release with RESET_PC=0, ack every request, no J/B -> imem_addr sequence 0,4,8,C. instr_valid is high every other cycle.
- Jump: pc=0x0040_0010, instr=0x0810_0020 (j), J=1 -> next imem_addr=0x0040_0080. With J=1 and B=1, zero=1 simultaneously -> still 0x0040_0080.
- Branch:
  - pc=0x100, instr=0x1000_FFFE (beq, offset -2), B=1, zero=1 -> next pc=0x0FC.
  - Same instruction with zero=0 -> next pc=0x104.
- Stall and wait states:
  - stall=1 for 3 ISSUE cycles -> pc and instr constant, no imem_req.
  - imem_ack delayed 2 cycles -> imem_req held 3 cycles and instr captured on the ack cycle.
- Timeout and wrap:
  - No ack for 16 FETCH cycles -> fetch_err=1, sticky until reset.
  - RESET_PC=0xFFFF_FFFC, no branch -> second fetch address 0x0000_0000.
